// File: rtl/muldiv_writeback_unit.sv
// -----------------------------------------------------------------------------
// muldiv_writeback_unit
//
// Purpose:
//   Iterative multiply/divide unit placed between the register file read ports
//   and its write port. It handles one operation at a time. The operands are
//   latched on an accepted Start. The unit then runs WIDTH single-bit
//   iterations. It finishes with a one-cycle writeback that drives the
//   register-file write port.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        asynchronous active-low reset (0 = reset)
//   Start      operation request, honoured only while Busy = 0
//   Op         00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
//   AData      operand A (multiplicand / dividend)
//   BData      operand B (multiplier / divisor)
//   DestAddr   destination register of the result
//   Busy       high from the accepting edge through the writeback cycle
//   Done       one-cycle pulse in the writeback cycle
//   DivByZero  with Done: divide/remainder op with a zero divisor
//   WriteData  result toward the register file (holds after writeback)
//   WriteAddr  destination toward the register file (holds after writeback)
//   WRF        register file write enable (never asserted for register 0)
// -----------------------------------------------------------------------------
module muldiv_writeback_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [WIDTH-1:0]  AData,
  input  logic [WIDTH-1:0]  BData,
  input  logic [ADDR_W-1:0] DestAddr,
  output logic              Busy,
  output logic              Done,
  output logic              DivByZero,
  output logic [WIDTH-1:0]  WriteData,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic              WRF
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;         // multiplicand, or dividend shifted out MSB first
  logic [WIDTH-1:0]    b_q, b_d;         // multiplier shifted out LSB first, or divisor
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;     // {hi, lo}: product, or {remainder, quotient}
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;
  logic                wrf_q, wrf_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;

  // Datapath for one iteration
  logic [WIDTH:0]      mul_sum;
  logic [2*WIDTH-1:0]  mul_acc;
  logic [WIDTH:0]      div_rem_sh;
  logic [WIDTH:0]      div_diff;
  logic                div_ge;
  logic [WIDTH-1:0]    div_rem_new;
  logic [2*WIDTH-1:0]  div_acc;
  logic [2*WIDTH-1:0]  acc_run;
  logic [WIDTH-1:0]    result;

  always_comb begin
    // Shift-add multiply. The high half accumulates the partial product.
    // Each step shifts the whole product right, so after WIDTH steps the
    // full 2*WIDTH-bit product is in place.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
    mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide. The remainder sits in the high half. Quotient bits
    // enter the low half from the right. The compare is WIDTH+1 bits wide
    // because the shifted remainder can carry one extra bit.
    div_rem_sh  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    div_diff    = div_rem_sh - {1'b0, b_q};
    div_ge      = (div_rem_sh >= {1'b0, b_q});
    div_rem_new = div_ge ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0];
    div_acc     = {div_rem_new, acc_q[WIDTH-2:0], div_ge};

    acc_run = op_q[1] ? div_acc : mul_acc;
    // MUL and DIVU take the low half (low product word or quotient).
    // MULHU and REMU take the high half (high product word or remainder).
    result  = op_q[0] ? acc_run[2*WIDTH-1:WIDTH] : acc_run[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    dest_d  = dest_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    wrf_d   = wrf_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          a_d     = AData;
          b_d     = BData;
          op_d    = Op;
          dest_d  = DestAddr;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        acc_d = acc_run;
        if (op_q[1]) begin
          a_d = a_q << 1;
        end else begin
          b_d = b_q >> 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = ST_WB;
          done_d  = 1'b1;
          wrf_d   = (dest_q != '0);
          // The multiply path shifts b_q, but the divide path keeps it, so
          // b_q still holds the latched divisor here for divide ops.
          dbz_d   = op_q[1] && (b_q == '0);
          wdata_d = result;
          waddr_d = dest_q;
        end
      end

      ST_WB: begin
        // Any Start seen while in this state is ignored.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wrf_d   = 1'b0;
        dbz_d   = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wrf_d   = 1'b0;
        dbz_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      wrf_q   <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      wrf_q   <= wrf_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign WRF       = wrf_q;
  assign WriteData = wdata_q;
  assign WriteAddr = waddr_q;

endmodule

// File: tb/tb_muldiv_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_writeback_unit
//
// Directed bench for muldiv_writeback_unit. A transaction-level model
// predicts the result from plain arithmetic. It predicts the handshake timing
// by counting cycles since acceptance. A compare process checks every output
// against the model on each falling edge. Directed tasks add literal
// expectations for each operation.
// -----------------------------------------------------------------------------
module tb_muldiv_writeback_unit;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic              Start = 1'b0;
  logic [1:0]        Op = 2'b00;
  logic [WIDTH-1:0]  AData = '0;
  logic [WIDTH-1:0]  BData = '0;
  logic [ADDR_W-1:0] DestAddr = '0;
  logic              Busy;
  logic              Done;
  logic              DivByZero;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] WriteAddr;
  logic              WRF;

  int total = 0;
  int bad   = 0;

  muldiv_writeback_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Op        (Op),
    .AData     (AData),
    .BData     (BData),
    .DestAddr  (DestAddr),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .WriteData (WriteData),
    .WriteAddr (WriteAddr),
    .WRF       (WRF)
  );

  always #5 Clk = ~Clk;

  // ---------------- transaction-level model ----------------
  logic              m_busy  = 1'b0;
  int                m_cnt   = 0;     // edges elapsed since the accepting edge
  logic [1:0]        m_op    = '0;
  logic [WIDTH-1:0]  m_b     = '0;
  logic [ADDR_W-1:0] m_dest  = '0;
  logic [WIDTH-1:0]  m_result = '0;
  logic [WIDTH-1:0]  m_wdata = '0;
  logic [ADDR_W-1:0] m_waddr = '0;

  function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (op)
      2'b00:   return p[WIDTH-1:0];
      2'b01:   return p[2*WIDTH-1:WIDTH];
      2'b10:   return (b == 0) ? {WIDTH{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_busy  = 1'b0;
      m_cnt   = 0;
      m_op    = '0;
      m_b     = '0;
      m_dest  = '0;
      m_result = '0;
      m_wdata = '0;
      m_waddr = '0;
    end else if (m_busy) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == WIDTH) begin
        m_wdata = m_result;
        m_waddr = m_dest;
      end else if (m_cnt == WIDTH + 1) begin
        m_busy = 1'b0;
      end
    end else if (Start) begin
      m_busy   = 1'b1;
      m_cnt    = 0;
      m_op     = Op;
      m_b      = BData;
      m_dest   = DestAddr;
      m_result = ref_result(Op, AData, BData);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clk) begin
    logic e_done, e_wrf, e_dbz;
    e_done = m_busy && (m_cnt == WIDTH);
    e_wrf  = e_done && (m_dest != 0);
    e_dbz  = e_done && m_op[1] && (m_b == 0);
    total = total + 1;
    if (Busy !== m_busy || Done !== e_done || WRF !== e_wrf ||
        DivByZero !== e_dbz || WriteData !== m_wdata || WriteAddr !== m_waddr) begin
      bad = bad + 1;
      $display("FAIL model_cmp t=%0t got busy=%b done=%b wrf=%b dbz=%b wdata=%h waddr=%0d need busy=%b done=%b wrf=%b dbz=%b wdata=%h waddr=%0d",
               $time, Busy, Done, WRF, DivByZero, WriteData, WriteAddr,
               m_busy, e_done, e_wrf, e_dbz, m_wdata, m_waddr);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string nm, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h need=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [ADDR_W-1:0] dest,
                        input logic [WIDTH-1:0] exp_data, input logic exp_dbz,
                        input int inject_at, input string nm);
    bit seen;
    @(negedge Clk);
    Start = 1'b1; Op = op; AData = a; BData = b; DestAddr = dest;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge Clk);
      // Operand inputs wander after acceptance; an optional extra Start probes
      // that a request during Busy is dropped.
      Start    = (i == inject_at);
      Op       = 2'(i);
      AData    = $urandom;
      BData    = $urandom;
      DestAddr = ADDR_W'(i + 9);
      if (i == 1) check({nm, "_busy_after_start"}, WIDTH'(Busy), 1);
      if (Done) begin
        seen = 1'b1;
        check({nm, "_latency"}, WIDTH'(i), WIDTH'(WIDTH + 1));
        check({nm, "_wdata"}, WriteData, exp_data);
        check({nm, "_waddr"}, WIDTH'(WriteAddr), WIDTH'(dest));
        check({nm, "_wrf"}, WIDTH'(WRF), WIDTH'(dest != 0));
        check({nm, "_dbz"}, WIDTH'(DivByZero), WIDTH'(exp_dbz));
      end
    end
    Start = 1'b0;
    if (!seen) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL %s_timeout got=no_done need=done_within_40_cycles", nm);
    end
    @(negedge Clk);
    check({nm, "_busy_after_wb"}, WIDTH'(Busy), 0);
    check({nm, "_wrf_after_wb"}, WIDTH'(WRF), 0);
    check({nm, "_done_after_wb"}, WIDTH'(Done), 0);
    check({nm, "_wdata_hold"}, WriteData, exp_data);
    $display("txn %s op=%0d a=%h b=%h dest=%0d result=%h", nm, op, a, b, dest, WriteData);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge Clk);
    check("reset_busy", WIDTH'(Busy), 0);
    check("reset_done", WIDTH'(Done), 0);
    check("reset_wrf", WIDTH'(WRF), 0);
    check("reset_dbz", WIDTH'(DivByZero), 0);
    check("reset_wdata", WriteData, 0);
    check("reset_waddr", WIDTH'(WriteAddr), 0);
    Rst = 1'b1;

    run_op(2'b00, 32'd7,        32'd6,        5'd3, 32'h0000002A, 1'b0, 0, "mul_7x6");
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 1'b0, 0, "mulhu_max");
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000001, 1'b0, 0, "mul_max");
    run_op(2'b10, 32'd100,      32'd7,        5'd5, 32'h0000000E, 1'b0, 0, "divu_100_7");
    run_op(2'b11, 32'd100,      32'd7,        5'd5, 32'h00000002, 1'b0, 0, "remu_100_7");
    run_op(2'b10, 32'h1234,     32'd0,        5'd6, 32'hFFFFFFFF, 1'b1, 0, "divu_by0");
    run_op(2'b11, 32'h1234,     32'd0,        5'd6, 32'h00001234, 1'b1, 0, "remu_by0");
    run_op(2'b00, 32'd9,        32'd11,       5'd8, 32'h00000063, 1'b0, 5, "mul_ignore_start");
    run_op(2'b00, 32'd2,        32'd3,        5'd0, 32'h00000006, 1'b0, 0, "mul_dest0");

    // Reset in the middle of a divide: outputs clear at once, nothing is written.
    @(negedge Clk);
    Start = 1'b1; Op = 2'b10; AData = 32'd1000; BData = 32'd3; DestAddr = 5'd6;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    check("mid_busy_before_rst", WIDTH'(Busy), 1);
    #2 Rst = 1'b0;
    #1;
    check("rst_async_busy", WIDTH'(Busy), 0);
    check("rst_async_done", WIDTH'(Done), 0);
    check("rst_async_wrf", WIDTH'(WRF), 0);
    check("rst_async_wdata", WriteData, 0);
    check("rst_async_waddr", WIDTH'(WriteAddr), 0);
    $display("txn reset_mid_divu busy=%b wdata=%h", Busy, WriteData);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    repeat (40) begin
      @(negedge Clk);
      check("no_write_after_abort", WIDTH'(WRF | Done | Busy), 0);
    end

    run_op(2'b00, 32'd3, 32'd5, 5'd7, 32'h0000000F, 1'b0, 0, "mul_3x5_after_rst");

    @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running need=finished");
    $fatal(1, "timeout");
  end

endmodule
